// File: rtl/sdiv_seq_if.sv
// sdiv_seq_if: start/done handshake and operand/result bus of the sequential
// signed divider. The master (controlling FSM) drives the request and
// operands. The slave (divider) returns status and results.
interface sdiv_seq_if #(
  parameter int D_WIDTH1 = 16,
  parameter int D_WIDTH2 = 8
);
  logic                start;
  logic [D_WIDTH1-1:0] div_a;
  logic [D_WIDTH2-1:0] div_b;
  logic                busy;
  logic                done;
  logic [D_WIDTH1-1:0] quot;
  logic [D_WIDTH2-1:0] rem;
  logic                dbz;
  logic                ovf;

  modport master (
    output start, div_a, div_b,
    input  busy, done, quot, rem, dbz, ovf
  );

  modport slave (
    input  start, div_a, div_b,
    output busy, done, quot, rem, dbz, ovf
  );
endinterface

// File: rtl/sdiv_seq.sv
// sdiv_seq: sequential signed two's-complement divider.
// The operands are converted to magnitudes. A restoring division produces one
// quotient bit per clock, and the signs are reapplied in a final SIGN cycle.
// Divide-by-zero skips the iteration. A quotient that cannot be represented
// (most-negative / -1) saturates and sets ovf.
// Optional macro SDIV_RND_EN adds a ROUND state that rounds the quotient half
// away from zero. The remainder still reports the truncating value.
module sdiv_seq #(
  parameter int D_WIDTH1 = 16,
  parameter int D_WIDTH2 = 8
) (
  input logic      clk,
  input logic      n_rst,
  sdiv_seq_if.slave bus
);

  localparam int CNT_W = $clog2(D_WIDTH1 + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CALC  = 2'd1;
  localparam logic [1:0] S_ROUND = 2'd2;
  localparam logic [1:0] S_SIGN  = 2'd3;

  localparam logic [D_WIDTH1-1:0] Q_MAX = {1'b0, {(D_WIDTH1-1){1'b1}}};
  localparam logic [D_WIDTH1-1:0] Q_MIN = {1'b1, {(D_WIDTH1-1){1'b0}}};

  // Magnitude as an unsigned value; the most-negative input maps to 2^(W-1).
  function automatic logic [D_WIDTH1-1:0] abs_a(input logic [D_WIDTH1-1:0] v);
    return v[D_WIDTH1-1] ? (~v + D_WIDTH1'(1)) : v;
  endfunction

  function automatic logic [D_WIDTH2-1:0] abs_b(input logic [D_WIDTH2-1:0] v);
    return v[D_WIDTH2-1] ? (~v + D_WIDTH2'(1)) : v;
  endfunction

  logic [1:0]          state_q, state_d;
  logic [D_WIDTH1-1:0] a_q, a_d;       // dividend shifting out, quotient shifting in
  logic [D_WIDTH2-1:0] b_q, b_d;       // divisor magnitude
  logic [D_WIDTH2-1:0] pr_q, pr_d;     // partial remainder, always < |b|
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                qsign_q, qsign_d;
  logic                rsign_q, rsign_d;
  logic                zdiv_q, zdiv_d;  // current operation has a zero divisor
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [D_WIDTH1-1:0] quot_q, quot_d;
  logic [D_WIDTH2-1:0] rem_q, rem_d;
  logic                dbz_q, dbz_d;
  logic                ovf_q, ovf_d;

  logic [D_WIDTH2:0]   shifted_s;
  logic                ge_s;
  logic [D_WIDTH2-1:0] trial_s;

  // Next-state logic: operand capture, one restoring step per CALC cycle, sign fix-up.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    pr_d    = pr_q;
    cnt_d   = cnt_q;
    qsign_d = qsign_q;
    rsign_d = rsign_q;
    zdiv_d  = zdiv_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;

    // Bring the next dividend bit into the remainder and trial-subtract |b|.
    // When ge_s holds, the difference is below |b| and fits in D_WIDTH2 bits.
    shifted_s = {pr_q, a_q[D_WIDTH1-1]};
    ge_s      = (shifted_s >= {1'b0, b_q});
    trial_s   = shifted_s[D_WIDTH2-1:0] - b_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = abs_a(bus.div_a);
          b_d     = abs_b(bus.div_b);
          qsign_d = bus.div_a[D_WIDTH1-1] ^ bus.div_b[D_WIDTH2-1];
          rsign_d = bus.div_a[D_WIDTH1-1];
          pr_d    = {D_WIDTH2{1'b0}};
          cnt_d   = CNT_W'(D_WIDTH1);
          busy_d  = 1'b1;
          zdiv_d  = (bus.div_b == {D_WIDTH2{1'b0}});
          state_d = (bus.div_b == {D_WIDTH2{1'b0}}) ? S_SIGN : S_CALC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        pr_d  = ge_s ? trial_s : shifted_s[D_WIDTH2-1:0];
        a_d   = {a_q[D_WIDTH1-2:0], ge_s};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
`ifdef SDIV_RND_EN
          state_d = S_ROUND;
`else
          state_d = S_SIGN;
`endif
        end else begin
          state_d = S_CALC;
        end
      end
`ifdef SDIV_RND_EN
      S_ROUND: begin
        // Round half away from zero on the magnitude. The sign is applied afterwards.
        if ({pr_q, 1'b0} >= {1'b0, b_q}) begin
          a_d = a_q + D_WIDTH1'(1);
        end else begin
          a_d = a_q;
        end
        state_d = S_SIGN;
      end
`endif
      S_SIGN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
        if (zdiv_q) begin
          quot_d = rsign_q ? Q_MIN : Q_MAX;
          rem_d  = {D_WIDTH2{1'b0}};
          dbz_d  = 1'b1;
          ovf_d  = 1'b0;
        end else begin
          dbz_d = 1'b0;
          rem_d = rsign_q ? (~pr_q + D_WIDTH2'(1)) : pr_q;
          if (qsign_q) begin
            // A negative magnitude of 2^(W-1) negates to the legal minimum.
            quot_d = ~a_q + D_WIDTH1'(1);
            ovf_d  = 1'b0;
          end else if (a_q[D_WIDTH1-1]) begin
            quot_d = Q_MAX;
            ovf_d  = 1'b1;
          end else begin
            quot_d = a_q;
            ovf_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers. Reset discards any in-flight operation.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      a_q     <= {D_WIDTH1{1'b0}};
      b_q     <= {D_WIDTH2{1'b0}};
      pr_q    <= {D_WIDTH2{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      qsign_q <= 1'b0;
      rsign_q <= 1'b0;
      zdiv_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= {D_WIDTH1{1'b0}};
      rem_q   <= {D_WIDTH2{1'b0}};
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      pr_q    <= pr_d;
      cnt_q   <= cnt_d;
      qsign_q <= qsign_d;
      rsign_q <= rsign_d;
      zdiv_q  <= zdiv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.quot = quot_q;
  assign bus.rem  = rem_q;
  assign bus.dbz  = dbz_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_sdiv_seq.sv
// tb_sdiv_seq: directed self-checking bench for sdiv_seq at default widths.
// Expected values are hand-computed. Rounded quotients and latencies are
// selected when SDIV_RND_EN is defined.
module tb_sdiv_seq;

`ifdef SDIV_RND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif
  localparam int LAT = RND ? 18 : 17;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int   errors = 0;
  int   checks = 0;
  logic [15:0] last_q;
  logic        last_dbz;

  sdiv_seq_if #(.D_WIDTH1(16), .D_WIDTH2(8)) bus ();

  sdiv_seq #(.D_WIDTH1(16), .D_WIDTH2(8)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] q_t;   // truncated quotient
    logic [15:0] q_r;   // rounded quotient
    logic [7:0]  r;
    logic        dbz;
    logic        ovf;
  } vec_t;

  vec_t vecs [15];

  task automatic test_reset();
    bus.start = 1'b0;
    bus.div_a = 16'h0000;
    bus.div_b = 8'h00;
    n_rst = 1'b0;
    #12;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.quot !== 16'h0000) begin errors++; $display("FAIL reset_quot got=%h exp=0000", bus.quot); end
    checks++; if (bus.rem !== 8'h00) begin errors++; $display("FAIL reset_rem got=%h exp=00", bus.rem); end
    checks++; if (bus.dbz !== 1'b0) begin errors++; $display("FAIL reset_dbz got=%b exp=0", bus.dbz); end
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", bus.ovf); end
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic test_vectors();
    int lat;
    logic [15:0] eq;
    int elat;
    vecs = '{
      '{16'h03E8, 8'h07, 16'h008E, 16'h008F, 8'h06, 1'b0, 1'b0},
      '{16'hFC18, 8'h07, 16'hFF72, 16'hFF71, 8'hFA, 1'b0, 1'b0},
      '{16'h03E8, 8'hF9, 16'hFF72, 16'hFF71, 8'h06, 1'b0, 1'b0},
      '{16'hFC18, 8'hF9, 16'h008E, 16'h008F, 8'hFA, 1'b0, 1'b0},
      '{16'h0064, 8'h00, 16'h7FFF, 16'h7FFF, 8'h00, 1'b1, 1'b0},
      '{16'hFF9C, 8'h00, 16'h8000, 16'h8000, 8'h00, 1'b1, 1'b0},
      '{16'h8000, 8'hFF, 16'h7FFF, 16'h7FFF, 8'h00, 1'b0, 1'b1},
      '{16'h8000, 8'h01, 16'h8000, 16'h8000, 8'h00, 1'b0, 1'b0},
      '{16'h0003, 8'h05, 16'h0000, 16'h0001, 8'h03, 1'b0, 1'b0},
      '{16'hFFFD, 8'h05, 16'h0000, 16'hFFFF, 8'hFD, 1'b0, 1'b0},
      '{16'h0007, 8'h02, 16'h0003, 16'h0004, 8'h01, 1'b0, 1'b0},
      '{16'h7FFF, 8'h7F, 16'h0102, 16'h0102, 8'h01, 1'b0, 1'b0},
      '{16'h03E8, 8'h80, 16'hFFF9, 16'hFFF8, 8'h68, 1'b0, 1'b0},
      '{16'h0000, 8'h05, 16'h0000, 16'h0000, 8'h00, 1'b0, 1'b0},
      '{16'h0000, 8'h00, 16'h7FFF, 16'h7FFF, 8'h00, 1'b1, 1'b0}
    };
    for (int i = 0; i < 15; i++) begin
      eq   = RND ? vecs[i].q_r : vecs[i].q_t;
      elat = vecs[i].dbz ? 1 : LAT;
      @(negedge clk);
      bus.start = 1'b1;
      bus.div_a = vecs[i].a;
      bus.div_b = vecs[i].b;
      @(posedge clk); #1;
      bus.start = 1'b0;
      checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        errors++; $display("FAIL accept_busy[%0d] got busy=%b done=%b exp busy=1 done=0", i, bus.busy, bus.done);
      end
      lat = 0;
      while (bus.done !== 1'b1 && lat < 40) begin
        @(posedge clk); #1;
        lat++;
      end
      checks++; if (lat !== elat) begin errors++; $display("FAIL latency[%0d] got=%0d exp=%0d", i, lat, elat); end
      checks++; if (bus.quot !== eq) begin errors++; $display("FAIL quot[%0d] got=%h exp=%h", i, bus.quot, eq); end
      checks++; if (bus.rem !== vecs[i].r) begin errors++; $display("FAIL rem[%0d] got=%h exp=%h", i, bus.rem, vecs[i].r); end
      checks++; if (bus.dbz !== vecs[i].dbz) begin errors++; $display("FAIL dbz[%0d] got=%b exp=%b", i, bus.dbz, vecs[i].dbz); end
      checks++; if (bus.ovf !== vecs[i].ovf) begin errors++; $display("FAIL ovf[%0d] got=%b exp=%b", i, bus.ovf, vecs[i].ovf); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL done_busy[%0d] got=%b exp=0", i, bus.busy); end
    end
  endtask

  task automatic test_reset_mid_calc();
    int lat;
    logic [15:0] eq;
    // The previous result (0/0) left quot=7FFF, dbz=1, so zeros here come from the reset.
    @(negedge clk);
    bus.start = 1'b1;
    bus.div_a = 16'hFC18;
    bus.div_b = 8'hF9;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL midrst_done got=%b exp=0", bus.done); end
    checks++; if (bus.quot !== 16'h0000) begin errors++; $display("FAIL midrst_quot got=%h exp=0000", bus.quot); end
    checks++; if (bus.rem !== 8'h00) begin errors++; $display("FAIL midrst_rem got=%h exp=00", bus.rem); end
    checks++; if (bus.dbz !== 1'b0) begin errors++; $display("FAIL midrst_dbz got=%b exp=0", bus.dbz); end
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL midrst_ovf got=%b exp=0", bus.ovf); end
    @(negedge clk);
    n_rst = 1'b1;
    // No stale operation may resume after reset.
    repeat (20) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL midrst_idle got busy=%b done=%b exp 0 0", bus.busy, bus.done);
    end
    // A fresh operation completes normally: 3 / 5.
    eq = RND ? 16'h0001 : 16'h0000;
    @(negedge clk);
    bus.start = 1'b1;
    bus.div_a = 16'h0003;
    bus.div_b = 8'h05;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (lat !== LAT) begin errors++; $display("FAIL midrst_lat got=%0d exp=%0d", lat, LAT); end
    checks++; if (bus.quot !== eq) begin errors++; $display("FAIL midrst_newq got=%h exp=%h", bus.quot, eq); end
    checks++; if (bus.rem !== 8'h03) begin errors++; $display("FAIL midrst_newr got=%h exp=03", bus.rem); end
    last_q   = eq;
    last_dbz = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] op_a [4];
    logic [7:0]  op_b [4];
    logic [15:0] exp_q [4];
    logic        exp_dbz [4];
    logic        exp_ovf [4];
    int          exp_e [4];
    int k;
    bit set_next;
    op_a = '{16'h03E8, 16'hFC18, 16'h0064, 16'h8000};
    op_b = '{8'h07, 8'h07, 8'h00, 8'hFF};
    exp_q = '{RND ? 16'h008F : 16'h008E, RND ? 16'hFF71 : 16'hFF72, 16'h7FFF, 16'h7FFF};
    exp_dbz = '{1'b0, 1'b0, 1'b1, 1'b0};
    exp_ovf = '{1'b0, 1'b0, 1'b0, 1'b1};
    exp_e = '{LAT, 2 * LAT + 1, 2 * LAT + 3, 3 * LAT + 4};
    @(negedge clk);
    bus.start = 1'b1;
    bus.div_a = op_a[0];
    bus.div_b = op_b[0];
    @(posedge clk); #1;   // edge 0 accepts op 0
    k = 0;
    set_next = 1'b1;
    for (int e = 0; e <= 80 && k < 4; e++) begin
      if (e > 0) begin
        @(posedge clk); #1;
      end
      if (bus.done === 1'b1) begin
        checks++; if (e !== exp_e[k]) begin errors++; $display("FAIL b2b_edge[%0d] got=%0d exp=%0d", k, e, exp_e[k]); end
        checks++; if (bus.quot !== exp_q[k]) begin errors++; $display("FAIL b2b_quot[%0d] got=%h exp=%h", k, bus.quot, exp_q[k]); end
        checks++; if (bus.dbz !== exp_dbz[k] || bus.ovf !== exp_ovf[k]) begin
          errors++; $display("FAIL b2b_flags[%0d] got dbz=%b ovf=%b exp dbz=%b ovf=%b", k, bus.dbz, bus.ovf, exp_dbz[k], exp_ovf[k]);
        end
        last_q   = exp_q[k];
        last_dbz = exp_dbz[k];
        k++;
        set_next = 1'b1;
      end else if (set_next) begin
        // Cycle after an accept: busy, and the next operands are queued on the held start.
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept[%0d] got busy=%b exp=1", k, bus.busy); end
        if (k + 1 < 4) begin
          bus.div_a = op_a[k + 1];
          bus.div_b = op_b[k + 1];
        end else begin
          bus.start = 1'b0;
        end
        set_next = 1'b0;
      end else begin
        checks++; if (bus.quot !== last_q || bus.dbz !== last_dbz) begin
          errors++; $display("FAIL b2b_hold[%0d] got q=%h dbz=%b exp q=%h dbz=%b", e, bus.quot, bus.dbz, last_q, last_dbz);
        end
      end
    end
    bus.start = 1'b0;
    checks++; if (k !== 4) begin errors++; $display("FAIL b2b_count got=%0d exp=4", k); end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_reset_mid_calc();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sdiv_seq.md
# sdiv_seq

Sequential signed two's-complement divider, the inverse datapath of the team's pipelined signed multiplier. It divides a D_WIDTH1-bit dividend by a D_WIDTH2-bit divisor. Both operands are converted to magnitudes, a restoring division produces one quotient bit per clock, and signs are reapplied at the end. It sits beside the multiplier in the arithmetic datapath and is driven by a start/done handshake from the controlling FSM.

## Interface
- D_WIDTH1, 16, dividend and quotient width (signed); must satisfy D_WIDTH1 >= D_WIDTH2
- D_WIDTH2, 8, divisor and remainder width (signed); must be >= 2
- clk  in  1  clock, rising edge
- n_rst  in  1  reset, asynchronous, active-low
- start  in  1  request; sampled only in IDLE
- div_a  in  D_WIDTH1  signed dividend; sampled on the start-accept edge
- div_b  in  D_WIDTH2  signed divisor; sampled on the start-accept edge
- busy  out  1  operation in progress (state != IDLE)
- done  out  1  one-cycle pulse; quot/rem/dbz/ovf valid from this cycle
- quot  out  D_WIDTH1  signed quotient, truncated toward zero
- rem  out  D_WIDTH2  signed remainder; sign follows the dividend, zero is +0
- dbz  out  1  divide-by-zero flag for the last result
- ovf  out  1  quotient-overflow flag for the last result

## Operation
- States: IDLE, CALC, ROUND (only with the macro), SIGN.
- IDLE, start=1 (edge N):
  - latch |div_a| as a D_WIDTH1-bit unsigned value, so the most-negative dividend gives magnitude 2^(D_WIDTH1-1)
  - latch |div_b| as a D_WIDTH2-bit unsigned value
  - latch sign_q = a_sign ^ b_sign and sign_r = a_sign
  - clear the partial remainder (D_WIDTH2+1 bits); load bit counter = D_WIDTH1
  - if div_b == 0, go to SIGN; otherwise go to CALC
- CALC, per cycle:
  - shift the dividend MSB into the partial remainder
  - trial-subtract |b|; if the result is non-negative, keep it and shift 1 into the quotient, else restore and shift 0
  - decrement the counter
  - after D_WIDTH1 iterations, go to ROUND (macro) or SIGN
- SIGN, one cycle: register quot, rem and flags, pulse done, go to IDLE.
  - quot = sign_q ? -mag_q : mag_q
  - rem = sign_r ? -mag_r : mag_r
- Divide by zero: dbz=1, ovf=0, rem=0. quot = 2^(D_WIDTH1-1)-1 if div_a >= 0, else -2^(D_WIDTH1-1).
- Overflow: if positive-signed mag_q exceeds 2^(D_WIDTH1-1)-1 (only -2^(D_WIDTH1-1) / -1), quot = 2^(D_WIDTH1-1)-1 and ovf=1. A negative-signed mag_q of 2^(D_WIDTH1-1) is legal.
- dbz and ovf are registered with each result and cleared by the next done.
- start while busy is ignored. start in the done cycle is accepted (state is IDLE).
- quot, rem, dbz and ovf hold until the next done.
- Reset at any time: state to IDLE; all registers and outputs (busy, done, quot, rem, dbz, ovf) to 0. Any in-flight operation is discarded.

## Timing
- Start sampled on edge N. Normal op: CALC occupies edges N+1..N+D_WIDTH1, SIGN at N+D_WIDTH1+1, done high in the following cycle. Latency is D_WIDTH1+1 edges (17 at defaults).
- With SDIV_RND_EN: one extra edge (18 at defaults).
- Divide by zero: SIGN at N+1; done after 1 edge.
- busy is high from edge N until the edge that raises done. busy and done are never high together.
- Throughput: one operation per D_WIDTH1+2 cycles when start is asserted back-to-back.

## Configuration
- SDIV_RND_EN defined: the ROUND state follows CALC.
  - if 2*mag_r >= |b|, mag_q increments (round half away from zero); overflow saturation then applies as above
  - rem still reports the truncating remainder
- SDIV_RND_EN undefined: no ROUND state; quotient truncates toward zero.

## Test plan
- Defaults, reset asserted mid-CALC -> busy, done, quot, rem, dbz and ovf read 0 next cycle. A new start then completes normally.
- 1000 / 7 -> quot 0x008E, rem 0x06, done 17 edges after start. With SDIV_RND_EN: quot 0x008F at 18 edges.
- -1000 / 7 -> quot 0xFF72, rem 0xFA. 1000 / -7 -> quot 0xFF72, rem 0x06. -1000 / -7 -> quot 0x008E, rem 0xFA.
- 100 / 0 -> quot 0x7FFF, rem 0, dbz=1, done after 1 edge. -100 / 0 -> quot 0x8000, dbz=1.
- -32768 / -1 -> quot 0x7FFF, ovf=1. -32768 / 1 -> quot 0x8000, ovf=0. 3 / 5 -> quot 0, rem 3. -3 / 5 -> quot 0, rem 0xFD.
- start held high continuously -> start pulses during busy are ignored. A new op is accepted in each done cycle; results and flags update only on done.
